// File: rtl/arcade_input_mapper.sv
// Player-input front end: PS/2 keys and two joystick words to per-player control vectors.
// Optional autofire is compiled in with ARCADE_INPUT_AUTOFIRE_EN.
//
// Coin FSM (one per player)
// state    | meaning
// ST_IDLE  | armed, waiting for a request rising edge
// ST_PULSE | coin bit high for COIN_PULSE cycles
// ST_GAP   | re-arm hold-off for COIN_PULSE cycles, edges dropped
module arcade_input_mapper #(
    parameter int          NUM_BTN       = 1,
    parameter logic [15:0] COIN_PULSE    = 16'd50000,
    parameter bit          COIN_ON_START = 1'b1,
    parameter logic [19:0] AUTOFIRE_DIV  = 20'd400000
) (
    input  logic               clk_sys,
    input  logic               RESET_N,
    input  logic [64:0]        ps2_key,
    input  logic [15:0]        joystick_0,
    input  logic [15:0]        joystick_1,
    input  logic [1:0]         rotate,
    input  logic [NUM_BTN-1:0] autofire_mask,
    output logic [NUM_BTN+5:0] p1_ctrl,
    output logic [NUM_BTN+5:0] p2_ctrl
);

    typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_GAP} coin_state_t;

    logic               tog_q, tog_armed;
    logic               pressed, extended, key_event;
    logic [8:0]         key_code;
    logic               kb_u, kb_d, kb_l, kb_r;
    logic [NUM_BTN-1:0] kb_btn;
    logic [1:0]         kb_start, kb_coin;

    logic [3:0]         dir_raw0, dir_raw1;
    logic [NUM_BTN-1:0] btn_raw0, btn_raw1, btn_gate;
    logic [1:0]         start_raw, coin_raw, coin_req, req_q;
    coin_state_t        coin_state [2];
    logic [15:0]        coin_cnt [2];

    logic unused_bits;
    assign unused_bits = ^{joystick_0[15:6+NUM_BTN], joystick_1[15:6+NUM_BTN]};

    function automatic logic btn_match(input int idx, input logic [8:0] code);
        case (idx)
            0:       return (code == 9'h029) || (code == 9'h014);
            1:       return code == 9'h011;
            2:       return code == 9'h012;
            3:       return code == 9'h01A;
            default: return 1'b0;
        endcase
    endfunction

    // d = {U, D, L, R}
    function automatic logic [3:0] rotate_dir(input logic [1:0] rot, input logic [3:0] d);
        case (rot)
            2'd1:    return {d[1], d[0], d[2], d[3]};
            2'd2:    return {d[0], d[1], d[3], d[2]};
            2'd3:    return {d[2], d[3], d[0], d[1]};
            default: return d;
        endcase
    endfunction

    function automatic logic [3:0] cleanup_dir(input logic [3:0] d);
        return {d[3] & ~d[2], d[2] & ~d[3], d[1] & ~d[0], d[0] & ~d[1]};
    endfunction

    assign pressed   = ps2_key[15:8] != 8'hF0;
    assign extended  = pressed ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
    assign key_code  = (ps2_key[63:24] != 40'd0) ? 9'd0 : {extended, ps2_key[7:0]};
    // The first cycle after reset only captures the toggle, so a stale event is not replayed.
    assign key_event = tog_armed && (ps2_key[64] != tog_q);

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            tog_q     <= 1'b0;
            tog_armed <= 1'b0;
            kb_u      <= 1'b0;
            kb_d      <= 1'b0;
            kb_l      <= 1'b0;
            kb_r      <= 1'b0;
            kb_btn    <= '0;
            kb_start  <= '0;
            kb_coin   <= '0;
        end else begin
            tog_q     <= ps2_key[64];
            tog_armed <= 1'b1;
            if (key_event) begin
                case (key_code[7:0])
                    8'h75:   kb_u <= pressed;
                    8'h72:   kb_d <= pressed;
                    8'h6B:   kb_l <= pressed;
                    8'h74:   kb_r <= pressed;
                    default: ;
                endcase
                case (key_code)
                    9'h005:  kb_start[0] <= pressed;
                    9'h006:  kb_start[1] <= pressed;
                    9'h02E:  kb_coin[0]  <= pressed;
                    9'h036:  kb_coin[1]  <= pressed;
                    default: ;
                endcase
                for (int i = 0; i < NUM_BTN; i++) begin
                    if (btn_match(i, key_code)) kb_btn[i] <= pressed;
                end
            end
        end
    end

    assign dir_raw0     = joystick_0[3:0] | {kb_u, kb_d, kb_l, kb_r};
    assign dir_raw1     = joystick_1[3:0];
    assign btn_raw0     = joystick_0[4 +: NUM_BTN] | kb_btn;
    assign btn_raw1     = joystick_1[4 +: NUM_BTN];
    assign start_raw[0] = joystick_0[4+NUM_BTN] | kb_start[0];
    assign start_raw[1] = joystick_1[4+NUM_BTN] | kb_start[1];
    assign coin_raw[0]  = joystick_0[5+NUM_BTN] | kb_coin[0];
    assign coin_raw[1]  = joystick_1[5+NUM_BTN] | kb_coin[1];
    assign coin_req     = coin_raw | (COIN_ON_START ? start_raw : 2'b00);

`ifdef ARCADE_INPUT_AUTOFIRE_EN
    logic [19:0] af_cnt;
    logic        af_phase;

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            af_cnt   <= '0;
            af_phase <= 1'b1;
        end else if (af_cnt == AUTOFIRE_DIV - 20'd1) begin
            af_cnt   <= '0;
            af_phase <= ~af_phase;
        end else begin
            af_cnt <= af_cnt + 20'd1;
        end
    end

    assign btn_gate = ~autofire_mask | {NUM_BTN{af_phase}};
`else
    logic unused_mask;
    assign unused_mask = ^autofire_mask;
    assign btn_gate    = '1;
`endif

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            req_q <= '0;
            for (int p = 0; p < 2; p++) begin
                coin_state[p] <= ST_IDLE;
                coin_cnt[p]   <= '0;
            end
        end else begin
            req_q <= coin_req;
            for (int p = 0; p < 2; p++) begin
                case (coin_state[p])
                    ST_IDLE: begin
                        if (coin_req[p] && !req_q[p]) begin
                            coin_state[p] <= ST_PULSE;
                            coin_cnt[p]   <= COIN_PULSE - 16'd1;
                        end
                    end
                    ST_PULSE: begin
                        if (coin_cnt[p] == 16'd0) begin
                            coin_state[p] <= ST_GAP;
                            coin_cnt[p]   <= COIN_PULSE - 16'd1;
                        end else begin
                            coin_cnt[p] <= coin_cnt[p] - 16'd1;
                        end
                    end
                    ST_GAP: begin
                        if (coin_cnt[p] == 16'd0) coin_state[p] <= ST_IDLE;
                        else coin_cnt[p] <= coin_cnt[p] - 16'd1;
                    end
                    default: coin_state[p] <= ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            p1_ctrl <= '0;
            p2_ctrl <= '0;
        end else begin
            p1_ctrl <= {coin_state[0] == ST_PULSE, start_raw[0], btn_raw0 & btn_gate,
                        cleanup_dir(rotate_dir(rotate, dir_raw0))};
            p2_ctrl <= {coin_state[1] == ST_PULSE, start_raw[1], btn_raw1 & btn_gate,
                        cleanup_dir(rotate_dir(rotate, dir_raw1))};
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Bench for arcade_input_mapper: directed vectors, a behavioural model checked every cycle,
// and literal expectations at the interesting points. Honours ARCADE_INPUT_AUTOFIRE_EN.
module tb_arcade_input_mapper;
    localparam int NB  = 2;
    localparam int CP  = 4;
    localparam int DIV = 3;

    logic          clk_sys = 1'b0;
    logic          RESET_N = 1'b0;
    logic [64:0]   ps2_key = '0;
    logic [15:0]   joystick_0 = '0;
    logic [15:0]   joystick_1 = '0;
    logic [1:0]    rotate = '0;
    logic [NB-1:0] autofire_mask = '0;
    logic [NB+5:0] p1_ctrl, p2_ctrl;

    int n_tests = 0;
    int n_fail  = 0;

    arcade_input_mapper #(
        .NUM_BTN(NB), .COIN_PULSE(16'(CP)), .COIN_ON_START(1'b1), .AUTOFIRE_DIV(20'(DIV))
    ) dut (
        .clk_sys(clk_sys), .RESET_N(RESET_N), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1), .rotate(rotate),
        .autofire_mask(autofire_mask), .p1_ctrl(p1_ctrl), .p2_ctrl(p2_ctrl)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Key functions: 0 U,1 D,2 L,3 R,4..7 btn0..3,8 start1,9 start2,10 coin1,11 coin2
    bit         fn_q [12];
    int         edge_k = 0;
    int         last_acc [2] = '{0, 0};
    bit         req_prev [2] = '{0, 0};
    bit         prev_tog = 0;
    bit         synced = 0;
    logic [7:0] exp1 = '0;
    logic [7:0] exp2 = '0;

    function automatic int key_fn(input logic [8:0] code);
        case (code[7:0])
            8'h75: return 0;
            8'h72: return 1;
            8'h6B: return 2;
            8'h74: return 3;
            default: ;
        endcase
        case (code)
            9'h029, 9'h014: return 4;
            9'h011: return (NB > 1) ? 5 : -1;
            9'h012: return (NB > 2) ? 6 : -1;
            9'h01A: return (NB > 3) ? 7 : -1;
            9'h005: return 8;
            9'h006: return 9;
            9'h02E: return 10;
            9'h036: return 11;
            default: return -1;
        endcase
    endfunction

    // cw: clockwise ring [0]=U [1]=R [2]=D [3]=L; a rotation is a ring shift.
    function automatic logic [3:0] model_dirs(input logic [3:0] cw, input logic [1:0] rot);
        int sh;
        logic [3:0] n;
        sh = (rot == 2'd1) ? 3 : (rot == 2'd2) ? 1 : (rot == 2'd3) ? 2 : 0;
        for (int i = 0; i < 4; i++) n[i] = cw[(i + sh) % 4];
        for (int i = 0; i < 2; i++) begin
            if (n[i] && n[i+2]) begin
                n[i]   = 1'b0;
                n[i+2] = 1'b0;
            end
        end
        return {n[0], n[2], n[3], n[1]};
    endfunction

    always @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int i = 0; i < 12; i++) fn_q[i] = 1'b0;
            edge_k = 0;
            last_acc = '{0, 0};
            req_prev = '{0, 0};
            synced = 0;
            exp1 = '0;
            exp2 = '0;
        end else begin
            edge_k++;
            for (int p = 0; p < 2; p++) begin
                logic [15:0] j;
                logic [3:0]  cw;
                logic [NB-1:0] b;
                logic st, cn, req, coin_on;
                logic [7:0] e;
                j = (p == 0) ? joystick_0 : joystick_1;
                if (p == 0) cw = {fn_q[2] | j[1], fn_q[1] | j[2], fn_q[3] | j[0], fn_q[0] | j[3]};
                else        cw = {j[1], j[2], j[0], j[3]};
                for (int i = 0; i < NB; i++) b[i] = j[4+i] | ((p == 0) ? fn_q[4+i] : 1'b0);
`ifdef ARCADE_INPUT_AUTOFIRE_EN
                for (int i = 0; i < NB; i++)
                    if (autofire_mask[i]) b[i] = b[i] & (((edge_k - 1) / DIV) % 2 == 0);
`endif
                st = j[4+NB] | fn_q[8+p];
                cn = j[5+NB] | fn_q[10+p];
                coin_on = (last_acc[p] > 0) && (edge_k > last_acc[p]) && (edge_k <= last_acc[p] + CP);
                req = cn | st;
                if (req && !req_prev[p] && (last_acc[p] == 0 || edge_k > last_acc[p] + 2*CP))
                    last_acc[p] = edge_k;
                req_prev[p] = req;
                e = {coin_on, st, b, model_dirs(cw, rotate)};
                if (p == 0) exp1 = e;
                else        exp2 = e;
            end
            if (synced && ps2_key[64] != prev_tog) begin
                logic pr, ex;
                logic [8:0] code;
                int f;
                pr = ps2_key[15:8] != 8'hF0;
                ex = pr ? (ps2_key[15:8] == 8'hE0) : (ps2_key[23:16] == 8'hE0);
                code = (ps2_key[63:24] != 0) ? 9'd0 : {ex, ps2_key[7:0]};
                f = key_fn(code);
                if (f >= 0) fn_q[f] = pr;
            end
            prev_tog = ps2_key[64];
            synced = 1;
        end
    end

    always @(negedge clk_sys) begin
        if (RESET_N) begin
            check("model_p1", p1_ctrl, exp1);
            check("model_p2", p2_ctrl, exp2);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic send_key(input logic [39:0] hi, input logic [23:0] bytes);
        ps2_key = {~ps2_key[64], hi, bytes};
    endtask

    logic [14:0] coin_tab;
    logic [14:0] start_tab;
    logic [11:0] af_s;
    logic        af_ok;
    int          af_tr;

    initial begin
        #22;
        check("reset_p1", p1_ctrl, 8'h00);
        check("reset_p2", p2_ctrl, 8'h00);
        @(negedge clk_sys);
        RESET_N = 1'b1;
        step(3);

        send_key(40'd0, 24'h000075);
        step(1);
        check("key_up_one_edge", p1_ctrl, 8'h00);
        step(1);
        check("key_up_make", p1_ctrl, 8'h08);
        send_key(40'd0, 24'h00F075);
        step(2);
        check("key_up_break", p1_ctrl, 8'h00);
        send_key(40'd0, 24'h00E075);
        step(2);
        check("key_e0_up_make", p1_ctrl, 8'h08);
        send_key(40'd0, 24'hE0F075);
        step(2);
        check("key_e0_up_break", p1_ctrl, 8'h00);
        send_key(40'h0000000001, 24'h000075);
        step(2);
        check("key_long_code_ignored", p1_ctrl, 8'h00);
        send_key(40'd0, 24'h000014);
        step(2);
        check("key_btn0", p1_ctrl, 8'h10);
        send_key(40'd0, 24'h000011);
        step(2);
        check("key_btn1", p1_ctrl, 8'h30);
        send_key(40'd0, 24'h00F014);
        step(1);
        send_key(40'd0, 24'h00F011);
        step(2);
        check("key_btn_release", p1_ctrl, 8'h00);

        rotate = 2'd1; joystick_0 = 16'h0002; joystick_1 = 16'h0001;
        step(1);
        check("rot_cw_left_to_up", p1_ctrl, 8'h08);
        check("rot_cw_p2_right_to_down", p2_ctrl, 8'h04);
        rotate = 2'd3; joystick_1 = 16'h0000;
        step(1);
        check("rot_180_left_to_right", p1_ctrl, 8'h01);
        rotate = 2'd0; joystick_0 = 16'h000C;
        step(1);
        check("cleanup_up_down", p1_ctrl, 8'h00);
        rotate = 2'd2; joystick_0 = 16'h0008;
        step(1);
        check("rot_ccw_up_to_left", p1_ctrl, 8'h02);
        rotate = 2'd1; joystick_0 = 16'h000A;
        step(1);
        check("rot_cw_up_left", p1_ctrl, 8'h09);
        rotate = 2'd0; joystick_0 = 16'h0000;
        step(2);

        // start pulses at offsets 0, 5, 9: second dropped in the gap, third accepted
        coin_tab  = 15'b011110000011110;
        start_tab = 15'b000001000100001;
        for (int e = 0; e < 15; e++) begin
            joystick_0 = start_tab[e] ? 16'h0040 : 16'h0000;
            step(1);
            check($sformatf("coin_seq_%0d", e), p1_ctrl, {coin_tab[e], start_tab[e], 6'b0});
        end
        joystick_0 = 16'h0000;
        step(10);

        send_key(40'd0, 24'h00002E);
        step(1);
        joystick_1 = 16'h0080;
        step(1);
        check("simul_p1_before", p1_ctrl, 8'h00);
        check("simul_p2_before", p2_ctrl, 8'h00);
        step(1);
        check("simul_p1_coin", p1_ctrl, 8'h80);
        check("simul_p2_coin", p2_ctrl, 8'h80);
        send_key(40'd0, 24'h00F02E);
        joystick_1 = 16'h0000;
        step(12);

        joystick_0 = 16'h0090;
        step(2);
        check("pre_reset_pulse", p1_ctrl, 8'h90);
        #2 RESET_N = 1'b0;
        #1;
        check("async_reset_p1", p1_ctrl, 8'h00);
        check("async_reset_p2", p2_ctrl, 8'h00);
        @(negedge clk_sys);
        RESET_N = 1'b1;
        step(1);
        check("held_btn_after_reset", p1_ctrl, 8'h10);
        step(1);
        check("held_coin_after_reset", p1_ctrl, 8'h90);
        joystick_0 = 16'h0000;
        step(12);

        autofire_mask = 2'b01;
        joystick_0 = 16'h0010;
        step(1);
        for (int i = 0; i < 12; i++) begin
            af_s[i] = p1_ctrl[4];
            step(1);
        end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
        af_ok = 1'b1;
        af_tr = 0;
        for (int i = 0; i < 6; i++) if (af_s[i+6] != af_s[i]) af_ok = 1'b0;
        for (int i = 0; i < 3; i++) if (af_s[i+3] == af_s[i]) af_ok = 1'b0;
        for (int i = 0; i < 6; i++) if (af_s[i] != af_s[(i+1) % 6]) af_tr++;
        if (af_tr != 2) af_ok = 1'b0;
        check("autofire_pattern", {7'b0, af_ok}, 8'h01);
`else
        check("no_autofire_steady", {4'b0, af_s[3:0]}, 8'h0F);
        check("no_autofire_steady_hi", af_s[11:4], 8'hFF);
`endif
        autofire_mask = 2'b00;
        for (int i = 0; i < 6; i++) begin
            step(1);
            check($sformatf("mask_off_steady_%0d", i), p1_ctrl, 8'h10);
        end
        joystick_0 = 16'h0000;
        step(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
